// File: rtl/vproc_mmu_bridge.sv
// vproc_mmu_bridge: queues vector-core memory requests and forwards them one at a time to the MMU,
// adding a fixed address offset and forcing an error response if the MMU stays silent too long.
module vproc_mmu_bridge #(
  parameter int unsigned MEM_W          = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ADDR_OFFSET    = 32'h0000_2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vproc_req_i,
  input  logic [31:0]      vproc_addr_i,
  input  logic             vproc_we_i,
  input  logic [3:0]       vproc_be_i,
  input  logic [MEM_W-1:0] vproc_wdata_i,
  output logic             vproc_rvalid_o,
  output logic             vproc_err_o,
  output logic [MEM_W-1:0] vproc_rdata_o,
  output logic             mmu_req_o,
  output logic [31:0]      mmu_addr_o,
  output logic             mmu_we_o,
  output logic [3:0]       mmu_be_o,
  output logic [MEM_W-1:0] mmu_wdata_o,
  input  logic             mmu_rvalid_i,
  input  logic             mmu_err_i,
  input  logic [MEM_W-1:0] mmu_rdata_i,
  output logic             busy_o,
  output logic             overflow_o,
  output logic             timeout_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW = 32 + 1 + 4 + MEM_W;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] fifo_q [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmo_q, tmo_inc;
  logic [31:0] head_addr, mmu_addr_q;
  logic [MEM_W-1:0] mmu_wdata_q, rdata_q;
  logic [3:0] mmu_be_q;
  logic mmu_we_q, err_q, ovf_q, to_q;
  logic full, push, pop, tmo_hit, done;
  assign full = cnt_q == CW'(FIFO_DEPTH);
  assign pop = state_q == ISSUE;
  // A full FIFO still accepts a request in the cycle its head is being popped.
  assign push = vproc_req_i && (!full || pop);
  assign head = fifo_q[rd_q];
  assign head_addr = head[EW-1 -: 32] + ADDR_OFFSET;
  assign tmo_inc = tmo_q == TW'(TIMEOUT_CYCLES) ? tmo_q : tmo_q + TW'(1);
  assign tmo_hit = state_q == WAIT && !mmu_rvalid_i && tmo_inc == TW'(TIMEOUT_CYCLES);
  assign done = state_q == WAIT && (mmu_rvalid_i || tmo_hit);
  always_comb begin
    state_d = state_q == IDLE  ? (cnt_q != '0 ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? (done ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      mmu_addr_q  <= '0;
      mmu_we_q    <= 1'b0;
      mmu_be_q    <= '0;
      mmu_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        fifo_q[wr_q] <= {vproc_addr_i, vproc_we_i, vproc_be_i, vproc_wdata_i};
        wr_q         <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      // Head is latched on the IDLE->ISSUE edge so the MMU sees it for the whole ISSUE cycle.
      if (state_q == IDLE && cnt_q != '0) begin
        mmu_addr_q  <= head_addr;
        mmu_we_q    <= head[MEM_W + 4];
        mmu_be_q    <= head[MEM_W +: 4];
        mmu_wdata_q <= head[MEM_W-1:0];
      end
      tmo_q <= state_q == WAIT ? tmo_inc : '0;
      if (done) begin
        rdata_q <= mmu_rvalid_i ? mmu_rdata_i : '0;
        err_q   <= mmu_rvalid_i ? mmu_err_i : 1'b1;
      end
      if (tmo_hit) to_q <= 1'b1;
      if (vproc_req_i && !push) ovf_q <= 1'b1;
    end
  end
  assign mmu_req_o      = state_q == ISSUE;
  assign mmu_addr_o     = mmu_addr_q;
  assign mmu_we_o       = mmu_we_q;
  assign mmu_be_o       = mmu_be_q;
  assign mmu_wdata_o    = mmu_wdata_q;
  assign vproc_rvalid_o = state_q == RESP;
  assign vproc_rdata_o  = rdata_q;
  assign vproc_err_o    = err_q;
  assign busy_o         = state_q != IDLE || cnt_q != '0;
  assign overflow_o     = ovf_q;
  assign timeout_o      = to_q;
endmodule

// File: tb/tb_vproc_mmu_bridge.sv
// tb_vproc_mmu_bridge: random and directed traffic against a transaction-timeline model;
// a monitor checks MMU requests and core responses popped from scoreboard queues.
module tb_vproc_mmu_bridge;
  localparam int D = 4, T = 16, NEVER = 1 << 30;
  localparam logic [31:0] OFF = 32'h0000_2000;
  logic clk = 1'b0, rst = 1'b1;
  logic vproc_req_i = 1'b0, vproc_we_i = 1'b0;
  logic [31:0] vproc_addr_i = '0, vproc_wdata_i = '0;
  logic [3:0] vproc_be_i = '0;
  logic vproc_rvalid_o, vproc_err_o, mmu_req_o, mmu_we_o, busy_o, overflow_o, timeout_o;
  logic [31:0] vproc_rdata_o, mmu_addr_o, mmu_wdata_o;
  logic [3:0] mmu_be_o;
  logic mmu_rvalid_i = 1'b0, mmu_err_i = 1'b0;
  logic [31:0] mmu_rdata_i = '0;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {int cyc; logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;} mreq_t;
  typedef struct {int cyc; logic [31:0] rdata; logic err;} rsp_t;
  typedef struct {int lat; logic [31:0] rdata; logic err;} mmu_t;
  mreq_t exp_m[$];
  rsp_t exp_r[$];
  mmu_t mmu_q[$];
  int iss_q[$], act_a[$], act_r[$];
  int last_resp = -100, ovf_at = NEVER, to_at = NEVER;
  int sched = -1;
  logic [31:0] sd;
  logic se;

  vproc_mmu_bridge #(.MEM_W(32), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(T), .ADDR_OFFSET(OFF)) dut (
    .clk(clk), .rst(rst),
    .vproc_req_i(vproc_req_i), .vproc_addr_i(vproc_addr_i), .vproc_we_i(vproc_we_i),
    .vproc_be_i(vproc_be_i), .vproc_wdata_i(vproc_wdata_i),
    .vproc_rvalid_o(vproc_rvalid_o), .vproc_err_o(vproc_err_o), .vproc_rdata_o(vproc_rdata_o),
    .mmu_req_o(mmu_req_o), .mmu_addr_o(mmu_addr_o), .mmu_we_o(mmu_we_o), .mmu_be_o(mmu_be_o),
    .mmu_wdata_o(mmu_wdata_o), .mmu_rvalid_i(mmu_rvalid_i), .mmu_err_i(mmu_err_i),
    .mmu_rdata_i(mmu_rdata_i), .busy_o(busy_o), .overflow_o(overflow_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // One cycle of stimulus; the model decides acceptance and schedules issue/response times.
  task automatic tick(input logic req, input logic [31:0] addr, input logic we, input logic [3:0] be,
                      input logic [31:0] wd, input int lat, input logic [31:0] rd, input logic er);
    int occ, iss, rsp;
    logic pop;
    @(negedge clk);
    while (iss_q.size() > 0 && iss_q[0] < cyc) void'(iss_q.pop_front());
    while (act_r.size() > 0 && act_r[0] < cyc) begin
      void'(act_r.pop_front());
      void'(act_a.pop_front());
    end
    occ = iss_q.size();
    pop = occ > 0 && iss_q[0] == cyc;
    check("busy", busy_o, act_a.size() > 0 && act_a[0] < cyc);
    check("overflow", overflow_o, cyc >= ovf_at);
    check("timeout", timeout_o, cyc >= to_at);
    vproc_req_i = req; vproc_addr_i = addr; vproc_we_i = we; vproc_be_i = be; vproc_wdata_i = wd;
    if (req) begin
      if (occ < D || pop) begin
        iss = (cyc + 2 > last_resp + 2) ? cyc + 2 : last_resp + 2;
        rsp = iss + 1 + (lat <= T ? lat : T);
        iss_q.push_back(iss);
        act_a.push_back(cyc);
        act_r.push_back(rsp);
        last_resp = rsp;
        exp_m.push_back('{iss, addr + OFF, we, be, wd});
        exp_r.push_back('{rsp, lat <= T ? rd : 32'h0, lat <= T ? er : 1'b1});
        mmu_q.push_back('{lat, rd, er});
        if (lat > T && rsp < to_at) to_at = rsp;
      end else if (ovf_at == NEVER) ovf_at = cyc + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, '0, '0, 1, '0, 1'b0);
  endtask

  // Requests are driven during reset on purpose; they must leave no trace.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      vproc_req_i = i[0];
      vproc_addr_i = $urandom;
    end
    exp_m.delete(); exp_r.delete(); iss_q.delete(); act_a.delete(); act_r.delete();
    last_resp = -100; ovf_at = NEVER; to_at = NEVER;
    @(negedge clk);
    rst = 1'b0;
    vproc_req_i = 1'b0;
    check("rst_rvalid", vproc_rvalid_o, 0);
    check("rst_err", vproc_err_o, 0);
    check("rst_rdata", vproc_rdata_o, 0);
    check("rst_mmu_req", mmu_req_o, 0);
    check("rst_mmu_addr", mmu_addr_o, 0);
    check("rst_mmu_we", mmu_we_o, 0);
    check("rst_mmu_be", mmu_be_o, 0);
    check("rst_mmu_wdata", mmu_wdata_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_timeout", timeout_o, 0);
  endtask

  // MMU responder: answers each issued request after its assigned latency; silent ones get a late, ignored rvalid.
  always @(negedge clk) begin
    mmu_t m;
    mmu_rvalid_i = cyc == sched;
    mmu_rdata_i = mmu_rvalid_i ? sd : $urandom;
    mmu_err_i = mmu_rvalid_i ? se : 1'($urandom);
    if (mmu_req_o && !rst && mmu_q.size() > 0) begin
      m = mmu_q.pop_front();
      sched = cyc + (m.lat <= T ? m.lat : T + 1 + int'($urandom_range(0, 1)));
      sd = m.rdata;
      se = m.err;
    end
  end

  always @(negedge clk) begin
    mreq_t e;
    rsp_t r;
    if (!rst && mmu_req_o) begin
      if (exp_m.size() == 0) begin
        tests++; fails++;
        $display("FAIL mmu_req_unexpected at cycle %0d: got request, expected none", cyc);
      end else begin
        e = exp_m.pop_front();
        check("mmu_req_cycle", cyc, e.cyc);
        check("mmu_addr", mmu_addr_o, e.addr);
        check("mmu_we", mmu_we_o, e.we);
        check("mmu_be", mmu_be_o, e.be);
        check("mmu_wdata", mmu_wdata_o, e.wdata);
      end
    end
    if (!rst && vproc_rvalid_o) begin
      if (exp_r.size() == 0) begin
        tests++; fails++;
        $display("FAIL rsp_unexpected at cycle %0d: got response, expected none", cyc);
      end else begin
        r = exp_r.pop_front();
        check("rsp_cycle", cyc, r.cyc);
        check("rsp_rdata", vproc_rdata_o, r.rdata);
        check("rsp_err", vproc_err_o, r.err);
      end
    end
  end

  initial begin
    do_reset(3);
    while (cyc < 9) idle(1);
    tick(1'b1, 32'h100, 1'b0, 4'hF, '0, 3, 32'hDEADBEEF, 1'b0);
    idle(10);
    tick(1'b1, 32'h40, 1'b1, 4'b0011, 32'h1234ABCD, 2, $urandom, 1'b0);
    idle(8);
    tick(1'b1, 32'hFFFFF000, 1'b0, 4'hF, '0, 1, $urandom, 1'b0);
    idle(6);
    for (int i = 0; i < 6; i++) tick(1'b1, 32'h300 + 32'(i * 4), 1'b0, 4'hF, '0, 10, $urandom, 1'b0);
    idle(80);
    tick(1'b1, 32'h500, 1'b0, 4'hF, '0, T + 100, $urandom, 1'b0);
    idle(30);
    tick(1'b1, 32'h600, 1'b0, 4'hF, '0, 10, $urandom, 1'b0);
    idle(4);
    do_reset(2);
    idle(30);
    tick(1'b1, 32'h700, 1'b0, 4'hF, '0, 2, 32'hCAFEF00D, 1'b1);
    idle(10);
    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 1) == 1, $urandom, 1'($urandom), 4'($urandom), $urandom,
           ($urandom_range(0, 9) == 0) ? T + 50 : int'($urandom_range(1, 12)), $urandom,
           $urandom_range(0, 7) == 0);
    for (int k = 0; k < 600 && (exp_r.size() != 0 || exp_m.size() != 0); k++) idle(1);
    check("drain_left", 32'(exp_r.size() + exp_m.size()), 0);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
